// File: rtl/store_pkg.sv
// store_pkg: shared store-buffer funct3 codes, drain FSM states and lane payload type.
package store_pkg;
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  typedef enum logic {IDLE, BUSY} drain_state_t;
  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } lanes_t;
endpackage

// File: rtl/store_align.sv
// store_align: steers rs2 data into byte lanes, builds strobes and flags misaligned/illegal stores.
module store_align
  import store_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        illegal
);
  always_comb begin
    wdata   = funct3 == F3_SB ? {4{data[7:0]}} : funct3 == F3_SH ? {2{data[15:0]}} : data;
    wstrb   = funct3 == F3_SB ? 4'b0001 << off : funct3 == F3_SH ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    illegal = funct3 == F3_SB ? 1'b0 : funct3 == F3_SH ? off[0] : funct3 == F3_SW ? off != 2'b00 : 1'b1;
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: queues aligned stores in a FIFO and drains them to memory over req/ack, flagging load hazards.
module store_buffer
  import store_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [2:0]    s_funct3,
  input  logic [AW-1:0] s_addr,
  input  logic [31:0]   s_data,
  output logic          m_req,
  input  logic          m_ack,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  output logic [3:0]    m_wstrb,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hazard,
  output logic          misalign_err,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);
  typedef struct packed {
    logic [AW-3:0] word;
    lanes_t        lanes;
  } entry_t;
  entry_t       fifo [DEPTH];
  logic [31:0]  al_wdata;
  logic [3:0]   al_wstrb;
  logic         illegal, accept, push, pop, load;
  logic [PW-1:0] wr_ptr, rd_ptr, ld_ptr;
  logic [PW:0]  count;
  drain_state_t state, state_nx;
  store_align u_align (
    .funct3  (s_funct3),
    .off     (s_addr[1:0]),
    .data    (s_data),
    .wdata   (al_wdata),
    .wstrb   (al_wstrb),
    .illegal (illegal)
  );
  assign s_ready = count != (PW+1)'(DEPTH);
  assign m_req   = state == BUSY;
  assign empty   = count == '0 && !m_req;
  // The in-flight head stays in the FIFO until its ack, so the next head sits at rd_ptr+1.
  always_comb begin
    accept   = s_valid && s_ready;
    push     = accept && !illegal;
    pop      = state == BUSY && m_ack;
    load     = state == IDLE ? count != '0 : pop && count > (PW+1)'(1);
    ld_ptr   = state == IDLE ? rd_ptr : rd_ptr + PW'(1);
    state_nx = load ? BUSY : pop ? IDLE : state;
  end
  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      ld_hazard |= ld_valid && ({1'b0, PW'(i) - rd_ptr} < count) && fifo[i].word == ld_addr[AW-1:2];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= '{word: s_addr[AW-1:2], lanes: '{wdata: al_wdata, wstrb: al_wstrb}};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      m_wstrb      <= '0;
    end else begin
      wr_ptr       <= wr_ptr + PW'(push);
      rd_ptr       <= rd_ptr + PW'(pop);
      count        <= count + (PW+1)'(push) - (PW+1)'(pop);
      misalign_err <= accept && illegal;
      if (load) begin
        m_addr  <= {fifo[ld_ptr].word, 2'b00};
        m_wdata <= fifo[ld_ptr].lanes.wdata;
        m_wstrb <= fifo[ld_ptr].lanes.wstrb;
      end
    end
endmodule
